mdio_master: RTL and testbench



---
 rtl/mdio_pkg.sv | 32 +++
 rtl/mdio_clk_gen.sv | 50 +++++
 rtl/mdio_master.sv | 192 +++++++++++++++++++
 tb/tb_mdio_master.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// MDIO master shared definitions: frame codes, FSM states and op helpers.
package mdio_pkg;

  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  localparam logic [1:0] OP_C22_WR   = 2'b01;
  localparam logic [1:0] OP_C22_RD   = 2'b10;
  localparam logic [1:0] OP_C45_ADDR = 2'b00;
  localparam logic [1:0] OP_C45_WR   = 2'b01;
  localparam logic [1:0] OP_C45_RD   = 2'b11;
  localparam logic [1:0] OP_C45_RINC = 2'b10;

  localparam logic [1:0] TA_WR = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_ST, S_OP, S_PHY,
    S_REG, S_TA, S_DATA, S_FIN, S_ERR
  } state_e;

  function automatic logic is_read(
    input logic c45, input logic [1:0] op);
    return c45 ? (op == OP_C45_RD || op == OP_C45_RINC)
               : (op == OP_C22_RD);
  endfunction

  function automatic logic is_illegal(
    input logic c45, input logic [1:0] op);
    return !c45 && op != OP_C22_WR && op != OP_C22_RD;
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: low-first 50% clock while run=1, with edge strobes
// asserted in the sys_clk cycle just before each MDC transition.
module mdio_clk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic mdc,
  output logic mdc_rise,
  output logic mdc_fall
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (!run) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      mdc_d = ~mdc_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc      = mdc_q;
  assign mdc_rise = run & wrap & ~mdc_q;
  assign mdc_fall = run & wrap & mdc_q;

endmodule

// File: rtl/mdio_master.sv
// MDIO management master: Clause 22/45 frame serialiser with
// optional preamble, TA acknowledge check and busy/done handshake.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV     = 10,
  parameter int PRE_LEN     = 32,
  parameter int SUPPORT_C45 = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start_flag,
  input  logic        c45,
  input  logic [1:0]  op,
  input  logic [4:0]  phy_add,
  input  logic [4:0]  reg_add,
  input  logic [15:0] write_reg_data,
  input  logic        preamble_en,
  input  logic        mdio_in,
  output logic [15:0] read_reg_data,
  output logic        busy,
  output logic        done,
  output logic        rd_err,
  output logic        mdio_en,
  output logic        mdio_o,
  output logic        mdc
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        c45_q, c45_d;
  logic        rd_q, rd_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        en_q, en_d;
  logic        o_q, o_d;

  logic        run, mdc_rise, mdc_fall;
  logic        c45_in;
  logic [1:0]  st_in;
  logic [15:0] fld;

  assign run = state_q != S_IDLE && state_q != S_FIN
            && state_q != S_ERR;

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .run      (run),
    .mdc      (mdc),
    .mdc_rise (mdc_rise),
    .mdc_fall (mdc_fall)
  );

  assign c45_in = (SUPPORT_C45 != 0) && c45;
  assign st_in  = c45_in ? ST_C45 : ST_C22;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c45_d   = c45_q;
    rd_d    = rd_q;
    op_d    = op_q;
    phy_d   = phy_q;
    reg_d   = reg_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    en_d    = en_q;
    o_d     = o_q;
    fld     = 16'hFFFF;
    unique case (state_q)
      S_IDLE: begin
        if (start_flag) begin
          c45_d = c45_in;
          rd_d  = is_read(c45_in, op);
          op_d  = op;
          phy_d = phy_add;
          reg_d = reg_add;
          tx_d  = write_reg_data;
          err_d = 1'b0;
          if (is_illegal(c45_in, op)) begin
            state_d = S_ERR;
          end else if (preamble_en) begin
            state_d = S_PRE;
            cnt_d   = 6'(PRE_LEN - 1);
            en_d    = 1'b1;
            o_d     = 1'b1;
          end else begin
            state_d = S_ST;
            cnt_d   = 6'd1;
            en_d    = 1'b1;
            o_d     = st_in[1];
          end
        end
      end
      S_ERR: begin
        state_d = S_FIN;
        err_d   = 1'b1;
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        if (mdc_rise) begin
          if (state_q == S_TA && cnt_q == 6'd0 && rd_q && mdio_in)
            err_d = 1'b1;
          if (state_q == S_DATA)
            rx_d = {rx_q[14:0], mdio_in};
        end
        if (mdc_fall) begin
          if (cnt_q != 6'd0) begin
            cnt_d = cnt_q - 6'd1;
            if (state_q == S_DATA)
              tx_d = {tx_q[14:0], 1'b0};
          end else begin
            case (state_q)
              S_PRE:   begin state_d = S_ST;   cnt_d = 6'd1;  end
              S_ST:    begin state_d = S_OP;   cnt_d = 6'd1;  end
              S_OP:    begin state_d = S_PHY;  cnt_d = 6'd4;  end
              S_PHY:   begin state_d = S_REG;  cnt_d = 6'd4;  end
              S_REG:   begin state_d = S_TA;   cnt_d = 6'd1;  end
              S_TA:    begin state_d = S_DATA; cnt_d = 6'd15; end
              default: state_d = S_FIN;
            endcase
          end
          case (state_d)
            S_ST:    fld = {14'd0, c45_q ? ST_C45 : ST_C22};
            S_OP:    fld = {14'd0, op_q};
            S_PHY:   fld = {11'd0, phy_q};
            S_REG:   fld = {11'd0, reg_q};
            S_TA:    fld = {14'd0, TA_WR};
            default: fld = 16'hFFFF;
          endcase
          o_d = (state_d == S_DATA) ? tx_d[15] : fld[cnt_d[3:0]];
          // Read frames release the pad from the first TA bit onward.
          if (state_d == S_FIN
              || (rd_q && (state_d == S_TA || state_d == S_DATA))) begin
            en_d = 1'b0;
            o_d  = 1'b1;
          end
          if (state_d == S_FIN && rd_q)
            rdata_d = rx_q;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      c45_q   <= 1'b0;
      rd_q    <= 1'b0;
      op_q    <= '0;
      phy_q   <= '0;
      reg_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      o_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c45_q   <= c45_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
      phy_q   <= phy_d;
      reg_q   <= reg_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      en_q    <= en_d;
      o_q     <= o_d;
    end
  end

  assign read_reg_data = rdata_q;
  assign busy          = state_q != S_IDLE;
  assign done          = state_q == S_FIN;
  assign rd_err        = err_q;
  assign mdio_en       = en_q;
  assign mdio_o        = o_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed self-checking bench for mdio_master with a simple PHY
// model that records MDC-rise bits and answers read frames.
module tb_mdio_master;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start_flag = 1'b0;
  logic        c45 = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [4:0]  phy_add = '0;
  logic [4:0]  reg_add = '0;
  logic [15:0] write_reg_data = '0;
  logic        preamble_en = 1'b1;
  logic        mdio_in = 1'b1;
  logic [15:0] read_reg_data;
  logic        busy, done, rd_err, mdio_en, mdio_o, mdc;

  int nchk = 0;
  int nerr = 0;

  logic        obit [64];
  logic        ebit [64];
  int          nrise = 0;
  int          cur_np = 32;
  logic        resp_ta = 1'b0;
  logic [15:0] resp_dat = '0;
  logic        mdc_p = 1'b0;
  logic        busy_p = 1'b0;

  mdio_master dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .start_flag     (start_flag),
    .c45            (c45),
    .op             (op),
    .phy_add        (phy_add),
    .reg_add        (reg_add),
    .write_reg_data (write_reg_data),
    .preamble_en    (preamble_en),
    .mdio_in        (mdio_in),
    .read_reg_data  (read_reg_data),
    .busy           (busy),
    .done           (done),
    .rd_err         (rd_err),
    .mdio_en        (mdio_en),
    .mdio_o         (mdio_o),
    .mdc            (mdc)
  );

  always #5 sys_clk = ~sys_clk;

  // PHY model: record pad at each MDC rise, drive next bit after fall.
  always @(negedge sys_clk) begin
    int j;
    if (busy && !busy_p) begin
      nrise   <= 0;
      mdio_in <= 1'b1;
    end else if (mdc && !mdc_p) begin
      if (nrise < 64) begin
        obit[nrise] <= mdio_o;
        ebit[nrise] <= mdio_en;
      end
      nrise <= nrise + 1;
    end else if (!mdc && mdc_p) begin
      j = 31 + cur_np - nrise;
      if (nrise == cur_np + 15)
        mdio_in <= resp_ta;
      else if (nrise >= cur_np + 16 && nrise < cur_np + 32)
        mdio_in <= resp_dat[j[3:0]];
      else
        mdio_in <= 1'b1;
    end
    mdc_p  <= mdc;
    busy_p <= busy;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic frame(
    input logic c, input logic [1:0] o,
    input logic [4:0] p, input logic [4:0] r,
    input logic [15:0] d, input logic pre,
    input logic ta, input logic [15:0] rdat,
    input logic poke,
    input logic [15:0] exp_rrd, input logic exp_err);
    int lat;
    int np;
    logic [31:0] obs, expw;
    logic wr, pre_ok, en_ok;
    c45 = c; op = o; phy_add = p; reg_add = r;
    write_reg_data = d; preamble_en = pre;
    resp_ta = ta; resp_dat = rdat;
    np = pre ? 32 : 0;
    cur_np = np;
    wr = c ? !o[1] : (o == 2'b01);
    expw = {c ? 2'b00 : 2'b01, o, p, r, 2'b10, d};
    @(negedge sys_clk);
    start_flag = 1'b1;
    @(negedge sys_clk);
    start_flag = 1'b0;
    lat = 1;
    while (!done && lat < 4000) begin
      @(negedge sys_clk);
      lat++;
      start_flag = poke && lat == 600;
      if (poke && lat == 600) begin
        write_reg_data = ~d;
        op = 2'b10;
      end
    end
    start_flag = 1'b0;
    chk("latency", lat, 2 * 10 * (np + 32) + 1);
    chk("rises", nrise, np + 32);
    pre_ok = 1'b1;
    for (int i = 0; i < np; i++) pre_ok &= obit[i];
    chk("preamble", {31'd0, pre_ok}, 1);
    for (int i = 0; i < 32; i++) obs[31-i] = obit[np+i];
    if (wr) chk("stream", obs, expw);
    else    chk("header", {18'd0, obs[31:18]}, {18'd0, expw[31:18]});
    en_ok = 1'b1;
    for (int i = 0; i < np + 32; i++)
      en_ok &= (ebit[i] == (wr || i < np + 14));
    chk("mdio_en", {31'd0, en_ok}, 1);
    chk("rdata", {16'd0, read_reg_data}, {16'd0, exp_rrd});
    chk("rd_err", {31'd0, rd_err}, {31'd0, exp_err});
    @(negedge sys_clk);
    chk("idle_pad", {27'd0, busy, done, mdio_en, mdio_o, mdc},
        32'b00010);
    chk("rdata_hold", {16'd0, read_reg_data}, {16'd0, exp_rrd});
  endtask

  initial begin
    int k;
    logic seen;
    #12;
    chk("rst_out", {26'd0, mdc, mdio_o, mdio_en, busy, done, rd_err},
        6'b010000);
    chk("rst_rdata", {16'd0, read_reg_data}, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    frame(1'b0, 2'b01, 5'd0, 5'd0, 16'h2100, 1'b1,
          1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    frame(1'b0, 2'b10, 5'd1, 5'd2, 16'h0000, 1'b1,
          1'b0, 16'hA5C3, 1'b0, 16'hA5C3, 1'b0);
    frame(1'b0, 2'b10, 5'd1, 5'd2, 16'h0000, 1'b1,
          1'b1, 16'hFFFF, 1'b0, 16'hFFFF, 1'b1);
    frame(1'b1, 2'b00, 5'd3, 5'd1, 16'h0000, 1'b0,
          1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
    frame(1'b1, 2'b11, 5'd3, 5'd1, 16'h0000, 1'b0,
          1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0);

    c45 = 1'b0; op = 2'b11;
    @(negedge sys_clk);
    start_flag = 1'b1;
    @(negedge sys_clk);
    start_flag = 1'b0;
    k = 1;
    while (!done && k < 20) begin
      @(negedge sys_clk);
      k++;
    end
    chk("ill_latency", k, 2);
    chk("ill_rd_err", {31'd0, rd_err}, 1);
    chk("ill_no_mdc", nrise, 0);
    @(negedge sys_clk);

    frame(1'b0, 2'b01, 5'd5, 5'd9, 16'hBEEF, 1'b1,
          1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0);

    c45 = 1'b0; op = 2'b01; phy_add = 5'd7; reg_add = 5'd7;
    write_reg_data = 16'h5555; preamble_en = 1'b1; cur_np = 32;
    @(negedge sys_clk);
    start_flag = 1'b1;
    @(negedge sys_clk);
    start_flag = 1'b0;
    k = 0;
    while (nrise < 20 && k < 3000) begin
      @(negedge sys_clk);
      k++;
    end
    chk("reach_bit20", {31'd0, nrise >= 20}, 1);
    #2 sys_rst = 1'b1;
    #1;
    chk("async_rst", {26'd0, mdc, mdio_o, mdio_en, busy, done, rd_err},
        6'b010000);
    chk("async_rdata", {16'd0, read_reg_data}, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge sys_clk);
      seen |= done;
    end
    sys_rst = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      seen |= done;
    end
    chk("no_done_rst", {31'd0, seen}, 0);

    frame(1'b0, 2'b01, 5'h1F, 5'h1F, 16'h0001, 1'b1,
          1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
